// File: rtl/uart_rx_fifo.sv
// Oversampling UART receiver with a show-ahead receive FIFO.
// Frames are start + DATA_BITS (LSB first) + optional parity + STOP_BITS.
// Each completed word is stored together with its framing and parity flags.
module uart_rx_fifo #(
  parameter int TICK_DIV   = 130,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int DEPTH      = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   rx,
  output logic [DATA_BITS-1:0]   out_data,
  output logic                   out_frame_err,
  output logic                   out_parity_err,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [$clog2(DEPTH):0] level,
  output logic                   overrun,
  input  logic                   clear_overrun
);

  localparam int TDW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int OSW = $clog2(OVERSAMPLE);
  localparam int BW  = $clog2(DATA_BITS + 1);
  localparam int AW  = $clog2(DEPTH);
  localparam int LW  = AW + 1;
  localparam int EW  = DATA_BITS + 2;

  localparam logic [TDW-1:0] TICK_LAST = TDW'(TICK_DIV - 1);
  localparam logic [OSW-1:0] HALF_LAST = OSW'(OVERSAMPLE / 2 - 1);
  localparam logic [OSW-1:0] FULL_LAST = OSW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0]  DATA_LAST = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0]  STOP_LAST = BW'(STOP_BITS - 1);
  localparam logic [LW-1:0]  LVL_FULL  = LW'(DEPTH);

  typedef enum logic [2:0] {
    IDLE, START, DATA, PAR, STOP, PUSH, BRK_WAIT
  } state_e;

  state_e               state_q, state_d;
  logic                 rx_meta_q, rxs_q;
  logic [TDW-1:0]       tdiv_q;
  logic [OSW-1:0]       tcnt_q;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic [BW-1:0]        bcnt_q, bcnt_d;
  logic                 ferr_q, ferr_d;
  logic                 perr_q, perr_d;
  logic                 tick, sample, start_entry, push;

  logic [EW-1:0]        mem_q [DEPTH];
  logic [AW-1:0]        wr_q, rd_q;
  logic [LW-1:0]        level_q;
  logic                 overrun_q;
  logic                 full, pop, wr_en, drop;
  logic [EW-1:0]        head;

  // Two-flop synchroniser; idles high so reset never looks like a start bit.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta_q <= 1'b1;
      rxs_q     <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rxs_q     <= rx_meta_q;
    end
  end

  assign tick        = (tdiv_q == TICK_LAST);
  assign start_entry = (state_q == IDLE) && !rxs_q;
  // Mid start bit after OVERSAMPLE/2 ticks, then one full bit period per sample.
  assign sample      = tick && (tcnt_q == ((state_q == START) ? HALF_LAST : FULL_LAST));

  // Oversample tick divider, realigned to the falling edge of each start bit.
  always_ff @(posedge clk) begin
    if (reset || start_entry || tick) tdiv_q <= '0;
    else                              tdiv_q <= tdiv_q + 1'b1;
  end

  // Ticks within the current bit; restarts at frame start and at every sample.
  always_ff @(posedge clk) begin
    if (reset || start_entry) tcnt_q <= '0;
    else if (tick) begin
      if (sample) tcnt_q <= '0;
      else        tcnt_q <= tcnt_q + 1'b1;
    end
  end

  // Receiver state and per-frame datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      shreg_q <= '0;
      bcnt_q  <= '0;
      ferr_q  <= 1'b0;
      perr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      bcnt_q  <= bcnt_d;
      ferr_q  <= ferr_d;
      perr_q  <= perr_d;
    end
  end

  // Frame sequencing: samples land at bit centres, PUSH lasts one clock.
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    bcnt_d  = bcnt_q;
    ferr_d  = ferr_q;
    perr_d  = perr_q;
    push    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!rxs_q) state_d = START;
      end
      START: begin
        if (sample) begin
          if (rxs_q) state_d = IDLE;   // start bit did not survive: glitch
          else begin
            state_d = DATA;
            bcnt_d  = '0;
            ferr_d  = 1'b0;
            perr_d  = 1'b0;
          end
        end
      end
      DATA: begin
        if (sample) begin
          shreg_d = {rxs_q, shreg_q[DATA_BITS-1:1]};
          if (bcnt_q == DATA_LAST) begin
            bcnt_d  = '0;
            state_d = (PARITY != 0) ? PAR : STOP;
          end else begin
            bcnt_d = bcnt_q + 1'b1;
          end
        end
      end
      PAR: begin
        if (sample) begin
          if (PARITY == 1) perr_d = ~(^{shreg_q, rxs_q});
          else             perr_d =   ^{shreg_q, rxs_q};
          state_d = STOP;
        end
      end
      STOP: begin
        if (sample) begin
          if (!rxs_q) ferr_d = 1'b1;
          if (bcnt_q == STOP_LAST) state_d = PUSH;
          else                     bcnt_d  = bcnt_q + 1'b1;
        end
      end
      PUSH: begin
        push    = 1'b1;
        // A low stop bit may be a break; wait for idle so it yields one word.
        state_d = ferr_q ? BRK_WAIT : IDLE;
      end
      BRK_WAIT: begin
        if (rxs_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign full  = (level_q == LVL_FULL);
  assign pop   = out_valid && out_ready;
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign wr_en = push && (!full || pop);
  assign drop  = push && full && !pop;

  // FIFO storage; the slot under the write pointer is free or being popped.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_q] <= {ferr_q, perr_q, shreg_q};
  end

  // Wrapping pointers and occupancy count.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_q    <= '0;
      rd_q    <= '0;
      level_q <= '0;
    end else begin
      if (wr_en) wr_q <= wr_q + 1'b1;
      if (pop)   rd_q <= rd_q + 1'b1;
      case ({wr_en, pop})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
    end
  end

  // Sticky overrun; a drop in the same cycle as a clear keeps it set.
  always_ff @(posedge clk) begin
    if (reset)              overrun_q <= 1'b0;
    else if (drop)          overrun_q <= 1'b1;
    else if (clear_overrun) overrun_q <= 1'b0;
  end

  // Show-ahead head, forced to zero when empty so stale entries never leak.
  assign head           = mem_q[rd_q];
  assign out_valid      = (level_q != '0);
  assign out_data       = out_valid ? head[DATA_BITS-1:0] : '0;
  assign out_parity_err = out_valid & head[DATA_BITS];
  assign out_frame_err  = out_valid & head[DATA_BITS+1];
  assign level          = level_q;
  assign overrun        = overrun_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench: four receiver configurations share one clock. Stimulus
// pushes the expected {frame_err, parity_err, data} before sending a frame;
// the monitor pops and compares each word the DUT hands over.
module tb_uart_rx_fifo;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [3:0] rst, rxl, rdy, clr;

  // A: 8N1, DEPTH 4.  B: even parity.  C: odd parity.  D: 7 data, 2 stop.
  logic [7:0] dA, dB, dC;
  logic [6:0] dD;
  logic       feA, peA, vA, ovA, feB, peB, vB, ovB;
  logic       feC, peC, vC, ovC, feD, peD, vD, ovD;
  logic [2:0] lvA;
  logic [3:0] lvB, lvC, lvD;

  uart_rx_fifo #(.TICK_DIV(2), .OVERSAMPLE(8), .DATA_BITS(8), .PARITY(0),
                 .STOP_BITS(1), .DEPTH(4)) u_a (
    .clk(clk), .reset(rst[0]), .rx(rxl[0]), .out_data(dA), .out_frame_err(feA),
    .out_parity_err(peA), .out_valid(vA), .out_ready(rdy[0]), .level(lvA),
    .overrun(ovA), .clear_overrun(clr[0]));

  uart_rx_fifo #(.TICK_DIV(2), .OVERSAMPLE(8), .DATA_BITS(8), .PARITY(2),
                 .STOP_BITS(1), .DEPTH(8)) u_b (
    .clk(clk), .reset(rst[1]), .rx(rxl[1]), .out_data(dB), .out_frame_err(feB),
    .out_parity_err(peB), .out_valid(vB), .out_ready(rdy[1]), .level(lvB),
    .overrun(ovB), .clear_overrun(clr[1]));

  uart_rx_fifo #(.TICK_DIV(2), .OVERSAMPLE(8), .DATA_BITS(8), .PARITY(1),
                 .STOP_BITS(1), .DEPTH(8)) u_c (
    .clk(clk), .reset(rst[2]), .rx(rxl[2]), .out_data(dC), .out_frame_err(feC),
    .out_parity_err(peC), .out_valid(vC), .out_ready(rdy[2]), .level(lvC),
    .overrun(ovC), .clear_overrun(clr[2]));

  uart_rx_fifo #(.TICK_DIV(2), .OVERSAMPLE(8), .DATA_BITS(7), .PARITY(0),
                 .STOP_BITS(2), .DEPTH(8)) u_d (
    .clk(clk), .reset(rst[3]), .rx(rxl[3]), .out_data(dD), .out_frame_err(feD),
    .out_parity_err(peD), .out_valid(vD), .out_ready(rdy[3]), .level(lvD),
    .overrun(ovD), .clear_overrun(clr[3]));

  int n_vec = 0;
  int n_bad = 0;
  int vcycA = 0;
  logic [10:0] q [4][$];

  function automatic logic [10:0] ex(input logic fe, input logic pe, input logic [8:0] d);
    return {fe, pe, d};
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  task automatic pop_chk(input int idx, input logic [10:0] got);
    if (q[idx].size() == 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL unexpected word on dut%0d: got %h, expected none", idx, got);
    end else begin
      chk($sformatf("word dut%0d", idx), 32'(got), 32'(q[idx].pop_front()));
    end
  endtask

  // Monitor: one word is consumed per cycle where valid && ready.
  always @(negedge clk) begin
    if (!rst[0] && vA) vcycA++;
    if (!rst[0] && vA && rdy[0]) pop_chk(0, {feA, peA, 1'b0, dA});
    if (!rst[1] && vB && rdy[1]) pop_chk(1, {feB, peB, 1'b0, dB});
    if (!rst[2] && vC && rdy[2]) pop_chk(2, {feC, peC, 1'b0, dC});
    if (!rst[3] && vD && rdy[3]) pop_chk(3, {feD, peD, 2'b00, dD});
  end

  // One bit period is 16 clocks (TICK_DIV 2 x OVERSAMPLE 8).
  task automatic send(input int idx, input int nb, input logic [8:0] d,
                      input bit haspar, input logic pb, input int ns, input logic [1:0] sv);
    rxl[idx] = 1'b0;
    repeat (16) @(negedge clk);
    for (int i = 0; i < nb; i++) begin
      rxl[idx] = d[i];
      repeat (16) @(negedge clk);
    end
    if (haspar) begin
      rxl[idx] = pb;
      repeat (16) @(negedge clk);
    end
    for (int i = 0; i < ns; i++) begin
      rxl[idx] = sv[i];
      repeat (16) @(negedge clk);
    end
    rxl[idx] = 1'b1;
    repeat (32) @(negedge clk);
  endtask

  initial begin
    rst = 4'hF; rxl = 4'hF; rdy = 4'hF; clr = 4'h0;
    repeat (3) @(negedge clk);
    rst = 4'h0;
    chk("reset valid", 32'(vA), 0);
    chk("reset level", 32'(lvA), 0);
    chk("reset overrun", 32'(ovA), 0);
    chk("reset flags", 32'({feA, peA}), 0);
    repeat (4) @(negedge clk);

    // Basic 8N1 word; ready held high so valid is a single-cycle pulse.
    q[0].push_back(ex(1'b0, 1'b0, 9'h0A5));
    send(0, 8, 9'h0A5, 1'b0, 1'b0, 1, 2'b01);
    chk("A5 level", 32'(lvA), 0);
    chk("A5 valid pulse", 32'(vcycA), 1);

    // Break: 20 bit periods low gives exactly one framing-error word.
    q[0].push_back(ex(1'b1, 1'b0, 9'h000));
    rxl[0] = 1'b0;
    repeat (320) @(negedge clk);
    rxl[0] = 1'b1;
    repeat (64) @(negedge clk);
    chk("break level", 32'(lvA), 0);
    chk("break one word", 32'(vcycA), 2);

    // Glitch of 3 clocks is rejected, then a clean frame.
    rxl[0] = 1'b0;
    repeat (3) @(negedge clk);
    rxl[0] = 1'b1;
    repeat (40) @(negedge clk);
    chk("glitch level", 32'(lvA), 0);
    chk("glitch no word", 32'(vcycA), 2);
    q[0].push_back(ex(1'b0, 1'b0, 9'h05A));
    send(0, 8, 9'h05A, 1'b0, 1'b0, 1, 2'b01);

    // Even parity on 0x03 (two ones): p=1 is an error, p=0 is clean.
    q[1].push_back(ex(1'b0, 1'b1, 9'h003));
    send(1, 8, 9'h003, 1'b1, 1'b1, 1, 2'b01);
    q[1].push_back(ex(1'b0, 1'b0, 9'h003));
    send(1, 8, 9'h003, 1'b1, 1'b0, 1, 2'b01);
    // Odd parity: results invert.
    q[2].push_back(ex(1'b0, 1'b0, 9'h003));
    send(2, 8, 9'h003, 1'b1, 1'b1, 1, 2'b01);
    q[2].push_back(ex(1'b0, 1'b1, 9'h003));
    send(2, 8, 9'h003, 1'b1, 1'b0, 1, 2'b01);

    // Overrun: five words into a four-entry FIFO with no consumer.
    rdy[0] = 1'b0;
    for (int v = 1; v <= 5; v++) begin
      if (v <= 4) q[0].push_back(ex(1'b0, 1'b0, 9'(v)));
      send(0, 8, 9'(v), 1'b0, 1'b0, 1, 2'b01);
    end
    chk("overrun level", 32'(lvA), 4);
    chk("overrun set", 32'(ovA), 1);
    rdy[0] = 1'b1;
    repeat (10) @(negedge clk);
    chk("drain level", 32'(lvA), 0);
    chk("overrun sticky", 32'(ovA), 1);
    clr[0] = 1'b1;
    @(negedge clk);
    clr[0] = 1'b0;
    chk("overrun cleared", 32'(ovA), 0);

    // 7 data bits, 2 stop bits, second stop low; held in FIFO and checked.
    rdy[3] = 1'b0;
    send(3, 7, 9'h055, 1'b0, 1'b0, 2, 2'b01);
    chk("D level", 32'(lvD), 1);
    chk("D frame_err", 32'(feD), 1);
    chk("D parity_err", 32'(peD), 0);
    chk("D data", 32'(dD), 32'h55);

    // Reset in the middle of the next frame's data bits.
    rxl[3] = 1'b0;
    repeat (16 + 48 + 5) @(negedge clk);
    rst[3] = 1'b1;
    repeat (2) @(negedge clk);
    rxl[3] = 1'b1;
    chk("D reset valid", 32'(vD), 0);
    chk("D reset level", 32'(lvD), 0);
    rst[3] = 1'b0;
    repeat (200) @(negedge clk);
    chk("D no stray word", 32'(lvD), 0);
    rdy[3] = 1'b1;
    q[3].push_back(ex(1'b0, 1'b0, 9'h03C));
    send(3, 7, 9'h03C, 1'b0, 1'b0, 2, 2'b11);
    chk("D final level", 32'(lvD), 0);

    for (int i = 0; i < 4; i++) chk($sformatf("dut%0d all words seen", i), 32'(q[i].size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
